// File: rtl/coffee_pkg.sv
// ---------------------------------------------------------------------------
// coffee_pkg
//   Shared types for the coffee machine access-code path.
//   scan_state_t : states of the code scanner (IDLE, SCAN, RESULT, LOCK)
//   max_int      : elaboration-time helper used to size shared counters
// ---------------------------------------------------------------------------
package coffee_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      RESULT = 2'd2,
      LOCK   = 2'd3
   } scan_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/code_scanner_fsm.sv
// ---------------------------------------------------------------------------
// code_scanner_fsm
//   Accepts a multi-digit access code one digit per strobe and compares it on
//   the fly against expected_code (digit 0 in the LSBs). Adds an inter-digit
//   timeout, consecutive-failure counting and a timed lockout.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active high
//   enable         in   session active; low aborts a scan without a pulse
//   digit_valid    in   digit strobe, one digit per high cycle
//   digit          in   digit value, sampled when digit_valid is high in SCAN
//   expected_code  in   reference code, digit 0 in LSBs, held stable in SCAN
//   code_valid     out  1-cycle pulse in RESULT when the code matched
//   code_invalid   out  1-cycle pulse in RESULT on mismatch or timeout
//   busy           out  high while in SCAN
//   locked         out  high while in LOCK
//   digit_cnt      out  digits accepted in the current/last attempt
//
// Input protocol: there is no back-pressure. A digit is consumed in every
// cycle where the FSM is in SCAN, enable is high and digit_valid is high;
// digit_valid in any other state is ignored. Dropping enable in SCAN aborts
// the attempt and takes priority over a digit strobe in the same cycle.
//
// The current FSM state is held in state_q for checkers to bind to.
// ---------------------------------------------------------------------------
module code_scanner_fsm #(
   parameter int CODE_LEN    = 4,
   parameter int DIGIT_W     = 4,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 1000,
   parameter int TIMEOUT_CYC = 500
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            digit_valid,
   input  logic [DIGIT_W-1:0]              digit,
   input  logic [CODE_LEN*DIGIT_W-1:0]     expected_code,
   output logic                            code_valid,
   output logic                            code_invalid,
   output logic                            busy,
   output logic                            locked,
   output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt
);

   import coffee_pkg::*;

   localparam int CW = $clog2(CODE_LEN + 1);
   localparam int FW = $clog2(MAX_TRIES + 1);
   // One down-counter serves both the inter-digit timeout and the lockout,
   // so it is sized for the larger of the two.
   localparam int TW = max_int($clog2(TIMEOUT_CYC), $clog2(LOCK_CYCLES) + 1);

   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] LOCK_LOAD    = TW'(LOCK_CYCLES - 1);
   localparam logic [CW-1:0] LAST_IDX     = CW'(CODE_LEN - 1);
   localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_TRIES);

   scan_state_t        state_q, state_nxt;
   logic [CW-1:0]      cnt_q, cnt_nxt;
   logic               mismatch_q, mismatch_nxt;
   logic [TW-1:0]      timer_q, timer_nxt;
   logic [FW-1:0]      fail_cnt, fail_nxt;
   logic [FW-1:0]      fail_inc;
   logic [DIGIT_W-1:0] cur_exp;

   // Reference digit for the position about to be entered.
   always_comb begin
      cur_exp = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (cnt_q == CW'(i)) begin
            cur_exp = expected_code[i*DIGIT_W +: DIGIT_W];
         end
      end
   end

   assign fail_inc = fail_cnt + FW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mismatch_q <= 1'b0;
         timer_q    <= '0;
         fail_cnt   <= '0;
      end else begin
         state_q    <= state_nxt;
         cnt_q      <= cnt_nxt;
         mismatch_q <= mismatch_nxt;
         timer_q    <= timer_nxt;
         fail_cnt   <= fail_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      cnt_nxt      = cnt_q;
      mismatch_nxt = mismatch_q;
      timer_nxt    = timer_q;
      fail_nxt     = fail_cnt;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_nxt    = SCAN;
               cnt_nxt      = '0;
               mismatch_nxt = 1'b0;
               timer_nxt    = TIMEOUT_LOAD;
            end
         end

         SCAN: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (digit_valid) begin
               mismatch_nxt = mismatch_q | (digit != cur_exp);
               cnt_nxt      = cnt_q + CW'(1);
               timer_nxt    = TIMEOUT_LOAD;
               if (cnt_q == LAST_IDX) begin
                  state_nxt = RESULT;
               end
            end else if (timer_q == '0) begin
               // Idle too long between digits: fail the attempt.
               mismatch_nxt = 1'b1;
               state_nxt    = RESULT;
            end else begin
               timer_nxt = timer_q - TW'(1);
            end
         end

         RESULT: begin
            if (mismatch_q) begin
               fail_nxt = fail_inc;
               if (fail_inc == FAIL_LIMIT) begin
                  state_nxt = LOCK;
                  timer_nxt = LOCK_LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               fail_nxt  = '0;
               state_nxt = IDLE;
            end
         end

         LOCK: begin
            if (timer_q == '0) begin
               fail_nxt  = '0;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer_q - TW'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // RESULT lasts exactly one cycle, so these are single-cycle pulses and
   // can never overlap.
   assign code_valid   = (state_q == RESULT) && !mismatch_q;
   assign code_invalid = (state_q == RESULT) &&  mismatch_q;
   assign busy         = (state_q == SCAN);
   assign locked       = (state_q == LOCK);
   assign digit_cnt    = cnt_q;

endmodule

// File: tb/tb_code_scanner_fsm.sv
`timescale 1ns/1ps
module tb_code_scanner_fsm;

   localparam int CODE_LEN    = 4;
   localparam int DIGIT_W     = 4;
   localparam int MAX_TRIES   = 3;
   localparam int LOCK_CYCLES = 40;
   localparam int TIMEOUT_CYC = 16;
   localparam logic [15:0] GOOD_CODE = 16'h9321;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        enable;
   logic        digit_valid;
   logic [3:0]  digit;
   logic [15:0] expected_code;
   logic        code_valid;
   logic        code_invalid;
   logic        busy;
   logic        locked;
   logic [2:0]  digit_cnt;

   code_scanner_fsm #(
      .CODE_LEN   (CODE_LEN),
      .DIGIT_W    (DIGIT_W),
      .MAX_TRIES  (MAX_TRIES),
      .LOCK_CYCLES(LOCK_CYCLES),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .expected_code(expected_code),
      .code_valid   (code_valid),
      .code_invalid (code_invalid),
      .busy         (busy),
      .locked       (locked),
      .digit_cnt    (digit_cnt)
   );

   int checks_total  = 0;
   int checks_passed = 0;
   int model_fail    = 0;

   // scoreboard: {code_valid, code_invalid, digit_cnt} per expected pulse
   logic [4:0] exp_q[$];
   logic [4:0] mon_got;
   logic [4:0] mon_exp;

   always @(negedge clk) begin
      if (!rst && (code_valid || code_invalid)) begin
         checks_total++;
         mon_got = {code_valid, code_invalid, digit_cnt};
         if (code_valid && code_invalid) begin
            $display("FAIL sb_both_pulses: got %b, required only one pulse", mon_got);
         end else if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected_pulse: got %b, required no pulse", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               $display("FAIL sb_result: got %b, required %b", mon_got, mon_exp);
            end else begin
               checks_passed++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
      $fatal(1, "watchdog");
   end

   // driver tasks (entered and left at posedge + 1)
   task automatic send_digit(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      @(posedge clk); #1;
      digit_valid = 1'b0;
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      enable = 1'b1;
      while (!busy && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      checks_total++;
      if (busy !== 1'b1) $display("FAIL %s_enter_scan: busy=%b, required 1", name, busy);
      else checks_passed++;
   endtask

   // Full code entry; leaves the bench in the RESULT cycle with enable low.
   task automatic enter_code(input logic [15:0] code, input int max_gap, input string name);
      logic       ok;
      logic [4:0] want;
      logic [4:0] got;
      ok   = (code == expected_code);
      want = ok ? {2'b10, 3'd4} : {2'b01, 3'd4};
      wait_busy(name);
      exp_q.push_back(want);
      for (int i = 0; i < CODE_LEN; i++) begin
         if (i > 0) repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk); #1;
         end
         if (i == CODE_LEN - 1) begin
            checks_total++;
            if ({busy, code_valid, code_invalid} !== 3'b100)
               $display("FAIL %s_before_last: busy/valid/invalid=%b, required 100",
                        name, {busy, code_valid, code_invalid});
            else checks_passed++;
         end
         send_digit(code[i*4 +: 4]);
      end
      enable = 1'b0;
      got = {code_valid, code_invalid, digit_cnt};
      checks_total++;
      if (got !== want) $display("FAIL %s_pulse: got %b, required %b", name, got, want);
      else checks_passed++;
      if (ok) model_fail = 0;
      else model_fail++;
   endtask

   task automatic check_fail_cnt(input string name);
      checks_total++;
      if (dut.fail_cnt !== 2'(model_fail))
         $display("FAIL %s_fail_cnt: got %0d, required %0d", name, dut.fail_cnt, model_fail);
      else checks_passed++;
   endtask

   // test scenarios
   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; digit_valid = 1'b0; digit = 4'h0;
      expected_code = GOOD_CODE;
      #1;
      checks_total++;
      if ({code_valid, code_invalid, busy, locked, digit_cnt} !== 7'b0)
         $display("FAIL reset_outputs: got %b, required 0",
                  {code_valid, code_invalid, busy, locked, digit_cnt});
      else checks_passed++;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_fail = 0;
      check_fail_cnt("reset");
   endtask

   task automatic test_match();
      enter_code(GOOD_CODE, 2, "match");
      check_fail_cnt("match");
   endtask

   task automatic test_mismatch();
      enter_code(16'h9421, 2, "mismatch");
      @(posedge clk); #1;
      check_fail_cnt("mismatch");
      checks_total++;
      if ({busy, locked} !== 2'b00) $display("FAIL mismatch_idle: busy/locked=%b, required 00", {busy, locked});
      else checks_passed++;
   endtask

   task automatic test_reset_scan();
      wait_busy("rst_scan");
      send_digit(4'h1);
      send_digit(4'h2);
      rst = 1'b1;
      #1;
      checks_total++;
      if ({busy, locked, digit_cnt} !== 5'b0)
         $display("FAIL rst_scan_async: busy/locked/cnt=%b, required 0", {busy, locked, digit_cnt});
      else checks_passed++;
      @(posedge clk); #1;
      rst = 1'b0; enable = 1'b0;
      model_fail = 0;
      check_fail_cnt("rst_scan");
   endtask

   task automatic test_abort();
      enter_code(16'h5555, 1, "abort_pre");
      wait_busy("abort");
      send_digit(4'h1);
      send_digit(4'h2);
      send_digit(4'h3);
      // abort and final digit strobe in the same cycle
      enable = 1'b0; digit_valid = 1'b1; digit = 4'h9;
      @(posedge clk); #1;
      digit_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks_total++;
      if ({busy, code_valid, code_invalid} !== 3'b000)
         $display("FAIL abort_idle: busy/valid/invalid=%b, required 000", {busy, code_valid, code_invalid});
      else checks_passed++;
      check_fail_cnt("abort");
      enter_code(GOOD_CODE, 1, "abort_retry");
      @(posedge clk); #1;
      check_fail_cnt("abort_retry");
   endtask

   task automatic test_timeout();
      logic early = 1'b0;
      wait_busy("timeout");
      send_digit(4'h1);
      send_digit(4'h2);
      exp_q.push_back({2'b01, 3'd2});
      for (int k = 1; k < TIMEOUT_CYC; k++) begin
         @(posedge clk); #1;
         if (code_invalid || !busy) early = 1'b1;
      end
      checks_total++;
      if (early) $display("FAIL timeout_early: pulse or exit before %0d idle cycles, required none", TIMEOUT_CYC);
      else checks_passed++;
      @(posedge clk); #1;
      enable = 1'b0;
      checks_total++;
      if ({code_invalid, digit_cnt} !== {1'b1, 3'd2})
         $display("FAIL timeout_pulse: invalid/cnt=%b, required 1010", {code_invalid, digit_cnt});
      else checks_passed++;
      model_fail++;
      @(posedge clk); #1;
      check_fail_cnt("timeout");
   endtask

   task automatic drive_to_lock(input string name);
      enter_code(GOOD_CODE, 0, name);
      for (int i = 0; i < MAX_TRIES; i++) enter_code(16'h1239, 1, name);
      @(posedge clk); #1;
   endtask

   task automatic test_lockout();
      int cnt = 0;
      drive_to_lock("lock");
      // inputs toggle throughout the lockout and must be ignored
      enable = 1'b1;
      for (int k = 0; k < LOCK_CYCLES + 5; k++) begin
         if (!locked) break;
         cnt++;
         digit_valid = 1'($urandom_range(0, 1));
         digit       = 4'($urandom_range(0, 15));
         @(posedge clk); #1;
      end
      enable = 1'b0; digit_valid = 1'b0;
      checks_total++;
      if (cnt != LOCK_CYCLES) $display("FAIL lock_length: got %0d cycles, required %0d", cnt, LOCK_CYCLES);
      else checks_passed++;
      model_fail = 0;
      check_fail_cnt("lock_exit");
   endtask

   task automatic test_back_to_back();
      logic [15:0] code;
      for (int n = 0; n < 8; n++) begin
         if (model_fail == MAX_TRIES - 1 || $urandom_range(0, 1) == 1) code = GOOD_CODE;
         else code = GOOD_CODE ^ (16'h1 << $urandom_range(0, 15));
         enter_code(code, 0, "b2b");
      end
      @(posedge clk); #1;
      check_fail_cnt("b2b");
   endtask

   task automatic test_reset_lock();
      drive_to_lock("rst_lock");
      repeat (5) @(posedge clk);
      #1;
      checks_total++;
      if (locked !== 1'b1) $display("FAIL rst_lock_pre: locked=%b, required 1", locked);
      else checks_passed++;
      rst = 1'b1;
      #1;
      checks_total++;
      if ({locked, busy, code_valid, code_invalid, digit_cnt} !== 7'b0)
         $display("FAIL rst_lock_async: got %b, required 0", {locked, busy, code_valid, code_invalid, digit_cnt});
      else checks_passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      model_fail = 0;
      check_fail_cnt("rst_lock");
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_reset_scan();
      test_abort();
      test_timeout();
      test_lockout();
      test_back_to_back();
      test_reset_lock();
      repeat (3) @(posedge clk);
      #1;
      checks_total++;
      if (exp_q.size() != 0) $display("FAIL sb_drain: %0d pulses outstanding, required 0", exp_q.size());
      else checks_passed++;
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
